// File: rtl/pdm_code_decoder.sv
// ---------------------------------------------------------------------------
// pdm_code_decoder
//
// Recovers a CODE_WIDTH-bit code from a 1-bit pulse-density stream. The ones
// are counted over a fixed window of 2^DECIM_LOG2 clock cycles. The count is
// then saturated to the largest DECIM_LOG2-bit value and left-aligned into
// CODE_WIDTH bits. The result is offered on a valid/ready output port.
// Windows run back to back with no dead cycles.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   pdm_in      pulse-density input; may be asynchronous to clk
//   enable      1 = accumulate windows; 0 = idle and drop any partial window
//   code_out    decoded code; held until a transfer or a newer result
//   code_valid  code_out holds an unconsumed result
//   code_ready  consumer accepts code_out when code_valid & code_ready
//   overrun     sticky; an unconsumed result was overwritten (cleared by rst)
// ---------------------------------------------------------------------------
module pdm_code_decoder #(
   parameter int CODE_WIDTH  = 10,
   parameter int DECIM_LOG2  = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pdm_in,
   input  logic                  enable,
   output logic [CODE_WIDTH-1:0] code_out,
   output logic                  code_valid,
   input  logic                  code_ready,
   output logic                  overrun
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   localparam logic [DECIM_LOG2-1:0] PHASE_ZERO = {DECIM_LOG2{1'b0}};
   localparam logic [DECIM_LOG2-1:0] PHASE_LAST = {DECIM_LOG2{1'b1}};
   localparam logic [DECIM_LOG2:0]   CNT_ZERO   = {(DECIM_LOG2+1){1'b0}};
   localparam logic [CODE_WIDTH-1:0] CODE_ZERO  = {CODE_WIDTH{1'b0}};
   localparam int                    SHIFT      = CODE_WIDTH - DECIM_LOG2;

   // Saturate a window count to the DECIM_LOG2-bit range, then left-align it.
   // Only an all-ones window sets the top count bit.
   function automatic logic [CODE_WIDTH-1:0] scale_sat(input logic [DECIM_LOG2:0] total);
      logic [DECIM_LOG2-1:0] sat;
      sat = total[DECIM_LOG2] ? PHASE_LAST : total[DECIM_LOG2-1:0];
      return CODE_WIDTH'(sat) << SHIFT;
   endfunction

   logic pdm_s;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign pdm_s = pdm_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         logic [SYNC_STAGES-1:0] sync_d;

         // Shift pdm_in into the synchroniser chain.
         always_comb begin
            sync_d[0] = pdm_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sync_d[i] = sync_q[i-1];
            end
         end

         // Synchroniser flops.
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= {SYNC_STAGES{1'b0}};
            end else begin
               sync_q <= sync_d;
            end
         end

         assign pdm_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   logic [0:0]            state_q, state_d;
   logic [DECIM_LOG2-1:0] phase_q, phase_d;
   logic [DECIM_LOG2:0]   ones_cnt_q, ones_cnt_d;
   logic [CODE_WIDTH-1:0] code_q, code_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic [DECIM_LOG2:0]   total_s;
   logic                  win_end_s;

   // Window FSM. The running total already includes the current sample, so the
   // window-end cycle sees the complete count without an extra cycle.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      ones_cnt_d = ones_cnt_q;
      win_end_s  = 1'b0;
      total_s    = ones_cnt_q + {{DECIM_LOG2{1'b0}}, pdm_s};
      case (state_q)
         ST_IDLE: begin
            phase_d    = PHASE_ZERO;
            ones_cnt_d = CNT_ZERO;
            if (enable) begin
               state_d = ST_ACCUM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (!enable) begin
               // Drop the partial window; no result is produced.
               state_d    = ST_IDLE;
               phase_d    = PHASE_ZERO;
               ones_cnt_d = CNT_ZERO;
            end else if (phase_q == PHASE_LAST) begin
               win_end_s  = 1'b1;
               phase_d    = PHASE_ZERO;
               ones_cnt_d = CNT_ZERO;
            end else begin
               phase_d    = phase_q + DECIM_LOG2'(1);
               ones_cnt_d = total_s;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            phase_d    = PHASE_ZERO;
            ones_cnt_d = CNT_ZERO;
         end
      endcase
   end

   // Output register and handshake. The newest result always wins. Losing an
   // unconsumed result sets overrun, unless the old result is taken in the same cycle.
   always_comb begin
      code_d    = code_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (win_end_s) begin
         code_d  = scale_sat(total_s);
         valid_d = 1'b1;
         if (valid_q && !code_ready) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_q;
         end
      end else if (valid_q && code_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State, window counters and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         phase_q    <= PHASE_ZERO;
         ones_cnt_q <= CNT_ZERO;
         code_q     <= CODE_ZERO;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         ones_cnt_q <= ones_cnt_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign code_out   = code_q;
   assign code_valid = valid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_pdm_code_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for pdm_code_decoder (CODE_WIDTH=10, DECIM_LOG2=10, SYNC_STAGES=2).
// A reference model tracks the delayed sample stream and a per-window ones
// count, and a negedge process compares every output on every cycle. Directed
// literal checks pin the model's results for each scenario.
// ---------------------------------------------------------------------------
module tb_pdm_code_decoder;

   localparam int CW  = 10;
   localparam int DL  = 10;
   localparam int SS  = 2;
   localparam int WIN = 1 << DL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pdm_in = 1'b0;
   logic          enable = 1'b0;
   logic          code_ready = 1'b1;
   logic [CW-1:0] code_out;
   logic          code_valid;
   logic          overrun;

   pdm_code_decoder #(.CODE_WIDTH(CW), .DECIM_LOG2(DL), .SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .rst        (rst),
      .pdm_in     (pdm_in),
      .enable     (enable),
      .code_out   (code_out),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Pattern source: 0 const 0, 1 const 1, 2 density 1/4, 3 density 1/2, 4 sigma-delta DAC
   int          mode = 0;
   int          cyc  = 0;
   int          dac_code = 0;
   logic [9:0]  dac_acc  = 10'd0;
   logic [10:0] dac_sum;

   // Reference model state
   bit sq[$];
   bit m_accum = 1'b0;
   int m_n = 0;
   int m_ones = 0;
   int e_code = 0;
   bit e_valid = 1'b0;
   bit e_ovr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_pdm();
      case (mode)
         0: pdm_in = 1'b0;
         1: pdm_in = 1'b1;
         2: pdm_in = ((cyc % 4) == 0);
         3: pdm_in = ((cyc % 2) == 0);
         default: begin
            dac_sum = {1'b0, dac_acc} + 11'(dac_code);
            dac_acc = dac_sum[9:0];
            pdm_in  = dac_sum[10];
         end
      endcase
   endtask

   task automatic set_mode(input int m);
      mode = m;
      drive_pdm();
   endtask

   task automatic start_dac(input int code);
      dac_code = code;
      dac_acc  = 10'd0;
      set_mode(4);
   endtask

   // Model one clock edge from the inputs presented before it.
   task automatic model_step();
      bit s;
      int total;
      bit win;
      win   = 1'b0;
      total = 0;
      if (rst) begin
         sq.delete();
         for (int i = 0; i < SS; i++) sq.push_back(1'b0);
         m_accum = 1'b0; m_n = 0; m_ones = 0;
         e_code = 0; e_valid = 1'b0; e_ovr = 1'b0;
      end else begin
         s = sq.pop_front();
         sq.push_back(pdm_in);
         if (!m_accum) begin
            if (enable) m_accum = 1'b1;
         end else if (!enable) begin
            m_accum = 1'b0; m_n = 0; m_ones = 0;
         end else begin
            m_ones += int'(s);
            m_n++;
            if (m_n == WIN) begin
               win = 1'b1; total = m_ones; m_n = 0; m_ones = 0;
            end
         end
         if (win) begin
            if (e_valid && !code_ready) e_ovr = 1'b1;
            e_code  = ((total > WIN - 1) ? WIN - 1 : total) << (CW - DL);
            e_valid = 1'b1;
         end else if (e_valid && code_ready) begin
            e_valid = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      drive_pdm();
   endtask

   // Count edges until code_valid is seen, bounded.
   task automatic wait_valid(input int max, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!code_valid && n < max);
      if (!code_valid) check("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; code_ready = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_code", 32'(code_out), 32'd0);
      check("reset_valid", 32'(code_valid), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
   endtask

   // Compare the DUT against the model on every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_valid", 32'(code_valid), 32'(e_valid));
         check("model_code", 32'(code_out), 32'(e_code));
         check("model_overrun", 32'(overrun), 32'(e_ovr));
      end
   end

   int n;
   int codes[4] = '{256, 1, 511, 1000};

   initial begin
      for (int i = 0; i < SS; i++) sq.push_back(1'b0);

      // 1: DAC stream decodes back to its code, one result per window
      foreach (codes[k]) begin
         do_reset();
         start_dac(codes[k]);
         enable = 1'b1;
         wait_valid(WIN + 8, n);
         wait_valid(WIN + 8, n);
         check("dac_period", 32'(n), 32'(WIN));
         check("dac_code", 32'(code_out), 32'(codes[k]));
      end

      // 2: saturation and zero
      do_reset();
      set_mode(1);
      enable = 1'b1;
      wait_valid(WIN + 8, n);
      wait_valid(WIN + 8, n);
      check("ones_period", 32'(n), 32'(WIN));
      check("ones_sat", 32'(code_out), 32'd1023);
      cycle();
      check("valid_pulse", 32'(code_valid), 32'd0);
      do_reset();
      set_mode(0);
      enable = 1'b1;
      wait_valid(WIN + 8, n);
      wait_valid(WIN + 8, n);
      check("zeros_code", 32'(code_out), 32'd0);

      // 3: three windows unconsumed, newest wins, overrun sticks
      do_reset();
      set_mode(2);
      code_ready = 1'b0;
      enable = 1'b1;
      wait_valid(WIN + 8, n);
      set_mode(3);
      repeat (2 * WIN) cycle();
      check("ovr_valid", 32'(code_valid), 32'd1);
      check("ovr_newest", 32'(code_out), 32'd512);
      check("ovr_set", 32'(overrun), 32'd1);
      code_ready = 1'b1;
      cycle();
      code_ready = 1'b0;
      check("ovr_drained", 32'(code_valid), 32'd0);
      check("ovr_sticky", 32'(overrun), 32'd1);
      check("ovr_held", 32'(code_out), 32'd512);

      // 4: transfer in the window-end cycle loads the new result without overrun
      do_reset();
      set_mode(0);
      code_ready = 1'b0;
      enable = 1'b1;
      wait_valid(WIN + 8, n);
      check("w4_first", 32'(code_out), 32'd0);
      set_mode(1);
      repeat (WIN - 1) cycle();
      code_ready = 1'b1;
      cycle();
      check("w4_valid", 32'(code_valid), 32'd1);
      check("w4_code", 32'(code_out), 32'd1022);
      check("w4_no_ovr", 32'(overrun), 32'd0);
      cycle();
      check("w4_consumed", 32'(code_valid), 32'd0);

      // 5: partial window dropped; full window after re-entry
      do_reset();
      start_dac(300);
      repeat (5) cycle();
      enable = 1'b1;
      repeat (WIN / 2 - 11) cycle();
      enable = 1'b0;
      repeat (10) cycle();
      check("partial_no_result", 32'(code_valid), 32'd0);
      enable = 1'b1;
      wait_valid(WIN + 8, n);
      check("reentry_latency", 32'(n), 32'(WIN + 1));
      check("reentry_code", 32'(code_out), 32'd300);

      // 6: rst mid-window with a pending result and overrun
      do_reset();
      start_dac(400);
      code_ready = 1'b0;
      enable = 1'b1;
      wait_valid(WIN + 8, n);
      repeat (WIN + 700) cycle();
      check("pre_rst_ovr", 32'(overrun), 32'd1);
      rst = 1'b1;
      cycle();
      check("rst_code", 32'(code_out), 32'd0);
      check("rst_valid", 32'(code_valid), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      rst = 1'b0;
      code_ready = 1'b1;
      wait_valid(WIN + 8, n);
      check("post_rst_latency", 32'(n), 32'(WIN + 1));

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
